// File: rtl/input_conditioner_pkg.sv
// Shared constants and types for the switch/button input conditioner.
package input_conditioner_pkg;

    // Debounce lengths: short one for simulation, long one for the board build.
    localparam int DEBOUNCE_CYCLES_SIM   = 4;
    localparam int DEBOUNCE_CYCLES_BOARD = 1_000_000;

    // Synchroniser depth used unless the instance overrides it.
    localparam int SYNC_STAGES_DEF = 2;

    // Width of the wrapping press counter.
    localparam int PCOUNT_W = 8;

    // Button edge-detector states.
    typedef enum logic {
        IDLE    = 1'b0,
        PRESSED = 1'b1
    } edge_state_e;

endpackage

// File: rtl/input_conditioner_if.sv
// Bundle of raw board inputs and conditioned outputs for input_conditioner.
// Signal flow: the board side (master) drives sw_raw/btn_raw as free-running
// asynchronous levels; the conditioner (slave) drives every other signal from
// registers. There is no valid/ready handshake: step is a single-cycle strobe
// that the consumer must sample on the clock edge following its assertion.
interface input_conditioner_if;
    import input_conditioner_pkg::*;

    logic                sw_raw;
    logic                btn_raw;
    logic                w;
    logic                btn_level;
    logic                step;
    logic [PCOUNT_W-1:0] press_count;
    edge_state_e         edge_state;   // debug view of the button edge FSM

    modport master (
        output sw_raw, btn_raw,
        input  w, btn_level, step, press_count, edge_state
    );

    modport slave (
        input  sw_raw, btn_raw,
        output w, btn_level, step, press_count, edge_state
    );

endinterface

// File: rtl/input_conditioner_debounce_bit.sv
// One raw asynchronous level -> synchroniser chain -> counter debouncer.
// The stable level only flips after DEBOUNCE_CYCLES consecutive synced cycles
// that disagree with it; any agreeing cycle restarts the count.
module debounce_bit #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level
);

    localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    logic                   stable_q, stable_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    // Shift the raw level through the synchroniser chain.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];

    // Count disagreeing cycles; flip the stable level when the count completes.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (synced != stable_q) begin
            if (cnt_q == CNT_MAX) begin
                stable_d = synced;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Debounce state registers; reset discards any partial count.
    always_ff @(posedge clk) begin
        if (reset) begin
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign level = stable_q;

endmodule

// File: rtl/input_conditioner.sv
// Conditions the board switch and push-button for the sequence detector:
// both inputs are synchronised and debounced, the switch becomes w, and each
// debounced button press yields one step pulse plus a wrapping press count.
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_SIM
) (
    input logic                 clk,
    input logic                 reset,
    input_conditioner_if.slave  cond
);

    logic                sw_level;
    logic                btn_level;
    edge_state_e         state_q, state_d;
    logic                step_q, step_d;
    logic [PCOUNT_W-1:0] pcount_q, pcount_d;

    debounce_bit #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_sw (
        .clk   (clk),
        .reset (reset),
        .raw   (cond.sw_raw),
        .level (sw_level)
    );

    debounce_bit #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn (
        .clk   (clk),
        .reset (reset),
        .raw   (cond.btn_raw),
        .level (btn_level)
    );

    // Edge FSM: the state lags btn_level by one cycle, so IDLE with the level
    // high is exactly the rising edge; falling edges only return to IDLE.
    always_comb begin
        state_d = state_q;
        step_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (btn_level) begin
                    state_d = PRESSED;
                    step_d  = 1'b1;
                end
            end
            PRESSED: begin
                if (!btn_level) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Count every step; the counter wraps silently.
    always_comb begin
        pcount_d = pcount_q;
        if (step_q) begin
            pcount_d = pcount_q + PCOUNT_W'(1);
        end
    end

    // FSM state, registered step strobe and press counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            step_q   <= 1'b0;
            pcount_q <= '0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            pcount_q <= pcount_d;
        end
    end

    assign cond.w           = sw_level;
    assign cond.btn_level   = btn_level;
    assign cond.step        = step_q;
    assign cond.press_count = pcount_q;
    assign cond.edge_state  = state_q;

endmodule
